// File: rtl/multi_led_blinker.sv
// N-channel LED blink sequencer sharing one prescaler tick; optional exclusive priority mode.
// Define HOLD_EN to add the per-channel hold input that freezes the toggle count.
module multi_led_blinker #(
   parameter int                 CLK_FREQ      = 40_000_000,
   parameter int                 TICK_HZ       = 4,
   parameter int                 N_CH          = 2,
   parameter logic [8*N_CH-1:0]  HALF_TICKS    = {8'd4, 8'd2},
   parameter logic [8*N_CH-1:0]  TOGGLES       = {8'd6, 8'd20},
   parameter int                 PRIORITY_MODE = 0
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [N_CH-1:0] trig,
`ifdef HOLD_EN
   input  logic [N_CH-1:0] hold,
`endif
   output logic [N_CH-1:0] led,
   output logic [N_CH-1:0] busy,
   output logic [N_CH-1:0] done,
   output logic            tick
);

   localparam int P_DIV = CLK_FREQ / TICK_HZ;
   localparam int P     = (P_DIV < 1) ? 1 : P_DIV;
   localparam int CW    = $clog2(P) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(P - 1);

   typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

   logic [CW-1:0]   cnt_reg, cnt_next;
   logic            tick_reg;
   logic [N_CH-1:0] trig_q_reg;
   logic [N_CH-1:0] rise;
   logic [N_CH-1:0] tog_nz;
   logic [N_CH-1:0] start;
   logic [N_CH-1:0] abort;
   logic [N_CH-1:0] busy_int;
   logic [N_CH-1:0] hold_int;

`ifdef HOLD_EN
   assign hold_int = hold;
`else
   assign hold_int = '0;
`endif

   always_comb begin
      cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CW'(1);
   end

   // tick is registered so it is 0 in reset and high exactly while cnt_reg == P-1
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_reg    <= '0;
         tick_reg   <= 1'b0;
         trig_q_reg <= '0;
      end else begin
         cnt_reg    <= cnt_next;
         tick_reg   <= (cnt_next == CNT_LAST);
         trig_q_reg <= trig;
      end
   end

   assign rise = trig & ~trig_q_reg;
   assign tick = tick_reg;
   assign busy = busy_int;

   always_comb begin : arbitration
      logic lower_start;
      logic lower_busy;
      start       = '0;
      abort       = '0;
      lower_start = 1'b0;
      lower_busy  = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (PRIORITY_MODE != 0) begin
            // a lower-index start pre-empts everything above it
            start[i]    = rise[i] & tog_nz[i] & ~lower_start & ~lower_busy;
            abort[i]    = lower_start;
            lower_start = lower_start | start[i];
            lower_busy  = lower_busy | busy_int[i];
         end else begin
            start[i] = rise[i] & tog_nz[i];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         localparam logic [7:0] H_RAW  = HALF_TICKS[8*gi +: 8];
         localparam logic [7:0] H_LAST = (H_RAW == 8'd0) ? 8'd0 : H_RAW - 8'd1;
         localparam logic [7:0] TOG    = TOGGLES[8*gi +: 8];

         state_t     state_reg, state_next;
         logic [7:0] phase_reg, phase_next;
         logic [7:0] tcnt_reg, tcnt_next;
         logic       led_reg, led_next;
         logic       done_reg, done_next;

         assign tog_nz[gi] = (TOG != 8'd0);

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               state_reg <= IDLE;
               phase_reg <= '0;
               tcnt_reg  <= '0;
               led_reg   <= 1'b0;
               done_reg  <= 1'b0;
            end else begin
               state_reg <= state_next;
               phase_reg <= phase_next;
               tcnt_reg  <= tcnt_next;
               led_reg   <= led_next;
               done_reg  <= done_next;
            end
         end

         always_comb begin
            state_next = state_reg;
            phase_next = phase_reg;
            tcnt_next  = tcnt_reg;
            led_next   = led_reg;
            done_next  = 1'b0;
            if (start[gi]) begin
               state_next = ACTIVE;
               phase_next = '0;
               tcnt_next  = '0;
               led_next   = 1'b1;
            end else if (abort[gi]) begin
               state_next = IDLE;
               phase_next = '0;
               tcnt_next  = '0;
               led_next   = 1'b0;
            end else if (state_reg == ACTIVE && tick_reg) begin
               if (phase_reg == H_LAST) begin
                  phase_next = '0;
                  if (hold_int[gi]) begin
                     led_next = ~led_reg;
                  end else if (tcnt_reg + 8'd1 == TOG) begin
                     // final toggle: LED forced off regardless of parity
                     state_next = IDLE;
                     tcnt_next  = '0;
                     led_next   = 1'b0;
                     done_next  = 1'b1;
                  end else begin
                     led_next  = ~led_reg;
                     tcnt_next = tcnt_reg + 8'd1;
                  end
               end else begin
                  phase_next = phase_reg + 8'd1;
               end
            end
         end

         assign led[gi]      = led_reg;
         assign done[gi]     = done_reg;
         assign busy_int[gi] = (state_reg == ACTIVE);
      end
   endgenerate

endmodule

// File: tb/tb_multi_led_blinker.sv
// Directed bench for multi_led_blinker: an independent-mode instance driven from a vector
// table plus hand-written sequences for priority, asynchronous reset and (with HOLD_EN) hold.
module tb_multi_led_blinker;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [1:0] trig_a, trig_b;
   logic [1:0] led_a, busy_a, done_a;
   logic [1:0] led_b, busy_b, done_b;
   logic       tick_a, tick_b;
`ifdef HOLD_EN
   logic [1:0] hold_a, hold_b;
`endif

   always #5 clk = ~clk;

   multi_led_blinker #(
      .CLK_FREQ(100), .TICK_HZ(10), .N_CH(2),
      .HALF_TICKS({8'd2, 8'd1}), .TOGGLES({8'd3, 8'd4}), .PRIORITY_MODE(0)
   ) dut_a (
      .clk(clk), .reset_n(reset_n), .trig(trig_a),
`ifdef HOLD_EN
      .hold(hold_a),
`endif
      .led(led_a), .busy(busy_a), .done(done_a), .tick(tick_a)
   );

   multi_led_blinker #(
      .CLK_FREQ(100), .TICK_HZ(10), .N_CH(2),
      .HALF_TICKS({8'd2, 8'd1}), .TOGGLES({8'd3, 8'd4}), .PRIORITY_MODE(1)
   ) dut_b (
      .clk(clk), .reset_n(reset_n), .trig(trig_b),
`ifdef HOLD_EN
      .hold(hold_b),
`endif
      .led(led_b), .busy(busy_b), .done(done_b), .tick(tick_b)
   );

   typedef struct {
      logic [1:0] trig;
      int         ncyc;
      logic [1:0] led;
      logic [1:0] busy;
      logic [1:0] done;
      logic       tick;
   } vec_t;

   vec_t vecs[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   d0_cnt, d1_cnt, multi_cnt, led_changes;
   logic prev_led;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   function automatic void add(input logic [1:0] t, input int n, input logic [1:0] l,
                               input logic [1:0] b, input logic [1:0] d, input logic tk);
      vec_t v;
      v.trig = t; v.ncyc = n; v.led = l; v.busy = b; v.done = d; v.tick = tk;
      vecs.push_back(v);
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      reset_n = 1'b0;
      trig_a  = '0;
      trig_b  = '0;
`ifdef HOLD_EN
      hold_a  = '0;
      hold_b  = '0;
`endif
      repeat (2) @(negedge clk);
      check("reset_a", {led_a, busy_a, done_a, tick_a}, 0);
      check("reset_b", {led_b, busy_b, done_b, tick_b}, 0);
      reset_n = 1'b1;

      // edge count E after release; ticks visible after E=9,19,..., consumed at E=10,20,...
      // ch0: H=1, 4 toggles.  ch1: H=2, 3 toggles.
      add(2'b01,  1, 2'b01, 2'b01, 2'b00, 1'b0);   // E1   ch0 start
      add(2'b00,  8, 2'b01, 2'b01, 2'b00, 1'b1);   // E9   first tick
      add(2'b00,  1, 2'b00, 2'b01, 2'b00, 1'b0);   // E10  toggle 1
      add(2'b00, 10, 2'b01, 2'b01, 2'b00, 1'b0);   // E20  toggle 2
      add(2'b00, 10, 2'b00, 2'b01, 2'b00, 1'b0);   // E30  toggle 3
      add(2'b00,  9, 2'b00, 2'b01, 2'b00, 1'b1);   // E39
      add(2'b00,  1, 2'b00, 2'b00, 2'b01, 1'b0);   // E40  done, led forced 0
      add(2'b00,  1, 2'b00, 2'b00, 2'b00, 1'b0);   // E41  done is one cycle
      add(2'b10,  1, 2'b10, 2'b10, 2'b00, 1'b0);   // E42  ch1 start
      add(2'b00, 17, 2'b10, 2'b10, 2'b00, 1'b1);   // E59
      add(2'b00,  1, 2'b00, 2'b10, 2'b00, 1'b0);   // E60  toggle 1
      add(2'b00, 20, 2'b10, 2'b10, 2'b00, 1'b0);   // E80  toggle 2
      add(2'b00, 19, 2'b10, 2'b10, 2'b00, 1'b1);   // E99
      add(2'b00,  1, 2'b00, 2'b00, 2'b10, 1'b0);   // E100 done ch1
      add(2'b00,  1, 2'b00, 2'b00, 2'b00, 1'b0);   // E101
      add(2'b01,  1, 2'b01, 2'b01, 2'b00, 1'b0);   // E102 ch0 start
      add(2'b00, 18, 2'b01, 2'b01, 2'b00, 1'b0);   // E120 after 2 toggles
      add(2'b01,  1, 2'b01, 2'b01, 2'b00, 1'b0);   // E121 retrigger, held high
      add(2'b01, 19, 2'b01, 2'b01, 2'b00, 1'b0);   // E140 still busy after restart
      add(2'b01, 20, 2'b00, 2'b00, 2'b01, 1'b0);   // E160 done after 4 fresh toggles
      add(2'b01, 10, 2'b00, 2'b00, 2'b00, 1'b0);   // E170 held trig: no restart
      add(2'b00,  1, 2'b00, 2'b00, 2'b00, 1'b0);   // E171
      add(2'b01,  1, 2'b01, 2'b01, 2'b00, 1'b0);   // E172 ch0 start
      add(2'b00, 37, 2'b00, 2'b01, 2'b00, 1'b1);   // E209 3 toggles done, completing tick pending
      add(2'b01,  1, 2'b01, 2'b01, 2'b00, 1'b0);   // E210 retrigger beats completion
      add(2'b00, 30, 2'b00, 2'b01, 2'b00, 1'b0);   // E240 3 toggles
      add(2'b00, 10, 2'b00, 2'b00, 2'b01, 1'b0);   // E250 done
      add(2'b00,  1, 2'b00, 2'b00, 2'b00, 1'b0);   // E251

      for (int i = 0; i < vecs.size(); i++) begin
         trig_a = vecs[i].trig;
         step(vecs[i].ncyc);
         $display("[TB] vec %0d trig=%b led=%b busy=%b done=%b tick=%b",
                  i, trig_a, led_a, busy_a, done_a, tick_a);
         check($sformatf("vec%0d_led", i),  led_a,  vecs[i].led);
         check($sformatf("vec%0d_busy", i), busy_a, vecs[i].busy);
         check($sformatf("vec%0d_done", i), done_a, vecs[i].done);
         check($sformatf("vec%0d_tick", i), tick_a, vecs[i].tick);
      end

      // priority instance: ch0 pre-empts ch1
      trig_b = 2'b10; step(1);                     // E252
      check("prio_ch1_start", {led_b, busy_b}, {2'b10, 2'b10});
      trig_b = 2'b00; step(9);                     // E261
      check("prio_ch1_led_on", led_b, 2'b10);
      trig_b = 2'b01; step(1);                     // E262
      $display("[TB] prio abort led=%b busy=%b done=%b", led_b, busy_b, done_b);
      check("prio_abort", {led_b, busy_b, done_b}, {2'b01, 2'b01, 2'b00});
      trig_b = 2'b00; step(1);
      trig_b = 2'b10; step(1);                     // E264
      $display("[TB] prio ignored trig1 busy=%b", busy_b);
      check("prio_ignore_lower", busy_b, 2'b01);
      trig_b = 2'b00;
      d0_cnt = 0; d1_cnt = 0; multi_cnt = 0;
      for (int k = 265; k <= 300; k++) begin
         step(1);
         if (done_b[0]) d0_cnt++;
         if (done_b[1]) d1_cnt++;
         if ($countones(busy_b) > 1) multi_cnt++;
      end
      check("prio_done_at_E300", {done_b, busy_b}, {2'b01, 2'b00});
      check("prio_ch0_done_cnt", d0_cnt, 1);
      check("prio_ch1_no_done", d1_cnt, 0);
      check("prio_one_busy", multi_cnt, 0);
      trig_b = 2'b11; step(1);                     // E301
      $display("[TB] prio simultaneous led=%b busy=%b", led_b, busy_b);
      check("prio_simul", {led_b, busy_b}, {2'b01, 2'b01});
      trig_b = 2'b00; step(39);                    // E340
      check("prio_simul_done", {done_b, busy_b}, {2'b01, 2'b00});

      // asynchronous reset mid-sequence
      trig_a = 2'b11; step(1);                     // E341
      check("pre_reset_busy", busy_a, 2'b11);
      trig_a = 2'b00; step(8);                     // E349
      check("pre_reset_tick", tick_a, 1'b1);
      reset_n = 1'b0;
      #1;
      $display("[TB] async reset led=%b busy=%b done=%b tick=%b", led_a, busy_a, done_a, tick_a);
      check("async_reset_a", {led_a, busy_a, done_a, tick_a}, 0);
      @(negedge clk);
      reset_n = 1'b1;
      d0_cnt = 0;
      for (int k = 0; k < 30; k++) begin
         step(1);
         if (done_a != 2'b00) d0_cnt++;
      end
      check("post_reset_busy", busy_a, 2'b00);
      check("post_reset_no_done", d0_cnt, 0);
      trig_a = 2'b01; step(1);                     // E'31
      check("post_reset_start", {led_a, busy_a}, {2'b01, 2'b01});
      trig_a = 2'b00; step(39);                    // E'70
      $display("[TB] post reset done=%b busy=%b", done_a, busy_a);
      check("post_reset_done", {done_a, busy_a}, {2'b01, 2'b00});

`ifdef HOLD_EN
      trig_a = 2'b01; step(1);                     // E'71
      check("hold_start", busy_a, 2'b01);
      trig_a = 2'b00;
      hold_a = 2'b01;
      d0_cnt = 0; led_changes = 0; prev_led = led_a[0];
      for (int k = 0; k < 200; k++) begin
         step(1);
         if (done_a[0]) d0_cnt++;
         if (led_a[0] != prev_led) led_changes++;
         prev_led = led_a[0];
      end
      $display("[TB] hold window toggles=%0d done=%0d", led_changes, d0_cnt);
      check("hold_blinks", led_changes, 20);
      check("hold_no_done", d0_cnt, 0);
      check("hold_busy", busy_a, 2'b01);
      hold_a = 2'b00; step(38);                    // E'309
      check("hold_release_busy", busy_a, 2'b01);
      step(1);                                     // E'310
      check("hold_release_done", {done_a, busy_a, led_a}, {2'b01, 2'b00, 2'b00});
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
